// File: rtl/hdr_pair_feeder.sv
// hdr_pair_feeder: SOP-aligned, lockstep, credit-throttled feeder for the HDR merge.
// Define PAIR_STATS_EN to add frame_count_o / mismatch_count_o.
module hdr_pair_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CREDITS    = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  asi_snk_0_valid_i,
   output logic                  asi_snk_0_ready_o,
   input  logic [DATA_WIDTH-1:0] asi_snk_0_data_i,
   input  logic                  asi_snk_0_startofpacket_i,
   input  logic                  asi_snk_0_endofpacket_i,
   input  logic                  asi_snk_1_valid_i,
   output logic                  asi_snk_1_ready_o,
   input  logic [DATA_WIDTH-1:0] asi_snk_1_data_i,
   input  logic                  asi_snk_1_startofpacket_i,
   input  logic                  asi_snk_1_endofpacket_i,
   output logic                  aso_src_0_valid_o,
   output logic [DATA_WIDTH-1:0] aso_src_0_data_o,
   output logic                  aso_src_0_startofpacket_o,
   output logic                  aso_src_0_endofpacket_o,
   output logic                  aso_src_1_valid_o,
   output logic [DATA_WIDTH-1:0] aso_src_1_data_o,
   output logic                  aso_src_1_startofpacket_o,
   output logic                  aso_src_1_endofpacket_o,
   input  logic                  credit_return_i,
`ifdef PAIR_STATS_EN
   output logic [15:0]           frame_count_o,
   output logic [7:0]            mismatch_count_o,
`endif
   output logic                  mismatch_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;
   localparam int EW = DATA_WIDTH + 2;
   localparam int CW = $clog2(CREDITS + 1);

   typedef enum logic {ALIGN, STREAM} state_t;
   state_t state_q, state_d;

   // Entry layout: {eop, sop, data}
   logic [EW-1:0] mem [2][FIFO_DEPTH];
   logic [EW-1:0] wr_ent [2];
   logic [EW-1:0] head [2];
   logic [AW-1:0] wr_ptr [2];
   logic [AW-1:0] rd_ptr [2];
   logic [NW-1:0] count [2];
   logic [NW-1:0] count_d [2];
   logic [1:0]    wr_en, pop, empty, ready_q, sop, eop;
   logic [CW-1:0] credit_q;
   logic          issue, mis, clean;

   assign wr_ent[0] = {asi_snk_0_endofpacket_i,
                       asi_snk_0_startofpacket_i,
                       asi_snk_0_data_i};
   assign wr_ent[1] = {asi_snk_1_endofpacket_i,
                       asi_snk_1_startofpacket_i,
                       asi_snk_1_data_i};
   assign wr_en = {asi_snk_1_valid_i & ready_q[1],
                   asi_snk_0_valid_i & ready_q[0]};
   assign asi_snk_0_ready_o = ready_q[0];
   assign asi_snk_1_ready_o = ready_q[1];

   always_comb begin
      empty = '0;
      sop   = '0;
      eop   = '0;
      for (int i = 0; i < 2; i++) begin
         head[i]  = mem[i][rd_ptr[i]];
         empty[i] = (count[i] == '0);
         sop[i]   = head[i][DATA_WIDTH];
         eop[i]   = head[i][DATA_WIDTH+1];
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++)
         count_d[i] = count[i] + NW'(wr_en[i]) - NW'(pop[i]);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (wr_en[i]) mem[i][wr_ptr[i]] <= wr_ent[i];
   end

   // Ready looks at next occupancy so a registered ready never admits into a full FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         ready_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])   rd_ptr[i] <= rd_ptr[i] + AW'(1);
            count[i]   <= count_d[i];
            ready_q[i] <= (count_d[i] != NW'(FIFO_DEPTH));
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ALIGN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (issue) state_d = (mis || clean) ? ALIGN : STREAM;
   end

   always_comb begin
      issue = 1'b0;
      pop   = '0;
      mis   = 1'b0;
      clean = 1'b0;
      unique case (state_q)
         ALIGN: begin
            pop   = ~empty & ~sop;
            issue = (empty == 2'b00) && (sop == 2'b11)
                    && (credit_q != '0);
         end
         STREAM: issue = (empty == 2'b00) && (credit_q != '0);
      endcase
      if (issue) begin
         pop   = 2'b11;
         mis   = (eop[0] ^ eop[1])
                 | ((state_q == STREAM) & (|sop));
         clean = (&eop) & ~mis;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         credit_q <= CW'(CREDITS);
      end else if (issue && !credit_return_i) begin
         credit_q <= credit_q - CW'(1);
      end else if (!issue && credit_return_i
                   && credit_q != CW'(CREDITS)) begin
         credit_q <= credit_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aso_src_0_valid_o         <= 1'b0;
         aso_src_1_valid_o         <= 1'b0;
         aso_src_0_data_o          <= '0;
         aso_src_1_data_o          <= '0;
         aso_src_0_startofpacket_o <= 1'b0;
         aso_src_1_startofpacket_o <= 1'b0;
         aso_src_0_endofpacket_o   <= 1'b0;
         aso_src_1_endofpacket_o   <= 1'b0;
         mismatch_o                <= 1'b0;
      end else begin
         aso_src_0_valid_o         <= issue;
         aso_src_1_valid_o         <= issue;
         aso_src_0_startofpacket_o <= issue & sop[0];
         aso_src_1_startofpacket_o <= issue & sop[1];
         aso_src_0_endofpacket_o   <= issue & eop[0];
         aso_src_1_endofpacket_o   <= issue & eop[1];
         mismatch_o                <= mis;
         if (issue) begin
            aso_src_0_data_o <= head[0][DATA_WIDTH-1:0];
            aso_src_1_data_o <= head[1][DATA_WIDTH-1:0];
         end
      end
   end

`ifdef PAIR_STATS_EN
   logic [15:0] frame_q;
   logic [7:0]  mis_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_q   <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (clean) frame_q <= frame_q + 16'd1;
         if (mis && mis_cnt_q != 8'hFF) mis_cnt_q <= mis_cnt_q + 8'd1;
      end
   end

   assign frame_count_o    = frame_q;
   assign mismatch_count_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_hdr_pair_feeder.sv
// Directed bench for hdr_pair_feeder: alignment, lockstep, credits, mismatch, reset.
// Build with +define+PAIR_STATS_EN to also cover the statistics counters.
`timescale 1ns/1ps
module tb_hdr_pair_feeder;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic s0_valid = 1'b0, s0_sop = 1'b0, s0_eop = 1'b0;
   logic s1_valid = 1'b0, s1_sop = 1'b0, s1_eop = 1'b0;
   logic [DW-1:0] s0_data = '0, s1_data = '0;
   logic s0_ready, s1_ready;
   logic o0_valid, o0_sop, o0_eop, o1_valid, o1_sop, o1_eop;
   logic [DW-1:0] o0_data, o1_data;
   logic credit_return_i = 1'b0;
   logic mismatch;
`ifdef PAIR_STATS_EN
   logic [15:0] frame_count;
   logic [7:0]  mismatch_count;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int lock_err = 0;
   bit auto_credit = 1'b0;
   logic [33:0] q0[$], q1[$], out0[$], out1[$];
   int cr_pend[$];
   int mis_log[$];

   hdr_pair_feeder dut (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .asi_snk_0_valid_i         (s0_valid),
      .asi_snk_0_ready_o         (s0_ready),
      .asi_snk_0_data_i          (s0_data),
      .asi_snk_0_startofpacket_i (s0_sop),
      .asi_snk_0_endofpacket_i   (s0_eop),
      .asi_snk_1_valid_i         (s1_valid),
      .asi_snk_1_ready_o         (s1_ready),
      .asi_snk_1_data_i          (s1_data),
      .asi_snk_1_startofpacket_i (s1_sop),
      .asi_snk_1_endofpacket_i   (s1_eop),
      .aso_src_0_valid_o         (o0_valid),
      .aso_src_0_data_o          (o0_data),
      .aso_src_0_startofpacket_o (o0_sop),
      .aso_src_0_endofpacket_o   (o0_eop),
      .aso_src_1_valid_o         (o1_valid),
      .aso_src_1_data_o          (o1_data),
      .aso_src_1_startofpacket_o (o1_sop),
      .aso_src_1_endofpacket_o   (o1_eop),
      .credit_return_i           (credit_return_i),
`ifdef PAIR_STATS_EN
      .frame_count_o             (frame_count),
      .mismatch_count_o          (mismatch_count),
`endif
      .mismatch_o                (mismatch)
   );

   always #5 clk = ~clk;

   // Source drivers: present queue head on negedge, retire it on accepted posedge
   always @(posedge clk) begin
      if (s0_valid && s0_ready && q0.size() > 0) void'(q0.pop_front());
      if (s1_valid && s1_ready && q1.size() > 0) void'(q1.pop_front());
   end

   always @(negedge clk) begin
      s0_valid = (q0.size() > 0);
      if (q0.size() > 0) {s0_eop, s0_sop, s0_data} = q0[0];
      s1_valid = (q1.size() > 0);
      if (q1.size() > 0) {s1_eop, s1_sop, s1_data} = q1[0];
   end

   // Output monitor and downstream credit model (return 20 cycles after each beat)
   always @(negedge clk) begin
      cyc++;
      if (o0_valid !== o1_valid) lock_err++;
      if (mismatch) mis_log.push_back(out0.size());
      if (o0_valid) begin
         out0.push_back({o0_eop, o0_sop, o0_data});
         if (auto_credit) cr_pend.push_back(cyc + 20);
      end
      if (o1_valid) out1.push_back({o1_eop, o1_sop, o1_data});
      credit_return_i = 1'b0;
      if (cr_pend.size() > 0 && cr_pend[0] <= cyc) begin
         void'(cr_pend.pop_front());
         credit_return_i = 1'b1;
      end
   end

   function automatic logic [33:0] ent(input bit sop, input bit eop, input int d);
      return {eop, sop, 32'(d)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int s, input int base, input int n, input int eop_at);
      for (int i = 0; i < n; i++) begin
         if (s == 0) q0.push_back(ent(i == 0, i == eop_at, base + i));
         else        q1.push_back(ent(i == 0, i == eop_at, base + i));
      end
   endtask

   task automatic push_raw(input int s, input logic [33:0] e);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_obs();
      out0.delete();
      out1.delete();
      mis_log.delete();
   endtask

   task automatic rst_on();
      reset_n = 1'b0;
      #1;
      q0.delete();
      q1.delete();
      cr_pend.delete();
      clear_obs();
   endtask

   task automatic rst_off();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset state and ready release timing
      cycles(3);
      chk("rst_valid0", o0_valid, 0);
      chk("rst_valid1", o1_valid, 0);
      chk("rst_mismatch", mismatch, 0);
      chk("rst_ready0", s0_ready, 0);
      chk("rst_ready1", s1_ready, 0);
      reset_n = 1'b1;
      #1;
      chk("ready_before_clk", s0_ready, 0);
      cycles(1);
      chk("ready_after_clk0", s0_ready, 1);
      chk("ready_after_clk1", s1_ready, 1);

      // Equal 4-beat packets
      auto_credit = 1'b1;
      push_pkt(0, 'h10, 4, 3);
      push_pkt(1, 'h20, 4, 3);
      cycles(40);
      chk("t1_count0", out0.size(), 4);
      chk("t1_count1", out1.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_s0_beat%0d", i), out0[i], ent(i == 0, i == 3, 'h10 + i));
         chk($sformatf("t1_s1_beat%0d", i), out1[i], ent(i == 0, i == 3, 'h20 + i));
      end
      chk("t1_no_mismatch", mis_log.size(), 0);

      // Stream 1 led by three non-SOP beats
      clear_obs();
      push_raw(1, ent(0, 0, 'hA0));
      push_raw(1, ent(0, 0, 'hA1));
      push_raw(1, ent(0, 0, 'hA2));
      push_pkt(0, 'h10, 4, 3);
      push_pkt(1, 'h20, 4, 3);
      cycles(40);
      chk("t2_count0", out0.size(), 4);
      chk("t2_count1", out1.size(), 4);
      chk("t2_first0", out0[0], ent(1, 0, 'h10));
      chk("t2_first1", out1[0], ent(1, 0, 'h20));
      chk("t2_last1", out1[3], ent(0, 1, 'h23));
      chk("t2_no_mismatch", mis_log.size(), 0);

      // Credit exhaustion and single return
      cycles(25);
      auto_credit = 1'b0;
      clear_obs();
      push_pkt(0, 'h100, 60, 59);
      push_pkt(1, 'h200, 60, 59);
      cycles(150);
      chk("t3_count0", out0.size(), 32);
      chk("t3_count1", out1.size(), 32);
      chk("t3_last0", out0[31], ent(0, 0, 'h11F));
      chk("t3_idle_valid", o0_valid, 0);
      chk("t3_full_ready0", s0_ready, 0);
      chk("t3_full_ready1", s1_ready, 0);
      cr_pend.push_back(cyc + 1);
      cycles(10);
      chk("t3_one_more0", out0.size(), 33);
      chk("t3_one_more1", out1.size(), 33);
      chk("t3_extra_beat1", out1[32], ent(0, 0, 'h220));

      // EOP disagreement
      rst_on();
      cycles(2);
      rst_off();
      auto_credit = 1'b1;
      push_pkt(0, 'h30, 4, 3);
      push_pkt(1, 'h40, 6, 5);
      push_pkt(0, 'h50, 2, 1);
      push_pkt(1, 'h60, 2, 1);
      cycles(50);
      chk("t4_count0", out0.size(), 6);
      chk("t4_count1", out1.size(), 6);
      chk("t4_mis_pulses", mis_log.size(), 1);
      chk("t4_mis_index", mis_log[0], 3);
      chk("t4_eop_pair0", out0[3], ent(0, 1, 'h33));
      chk("t4_eop_pair1", out1[3], ent(0, 0, 'h43));
      chk("t4_realign1", out1[4], ent(1, 0, 'h60));
      chk("t4_realign_end0", out0[5], ent(0, 1, 'h51));

      // Reset mid-packet
      rst_on();
      cycles(2);
      rst_off();
      auto_credit = 1'b1;
      push_pkt(0, 'h70, 10, 9);
      cycles(12);
      push_pkt(1, 'hC0, 10, 9);
      for (int i = 0; i < 30 && out0.size() < 3; i++) cycles(1);
      chk("t5_progress", out0.size() >= 3, 1);
      rst_on();
      chk("t5_rst_valid0", o0_valid, 0);
      chk("t5_rst_valid1", o1_valid, 0);
      chk("t5_rst_data0", o0_data, 0);
      chk("t5_rst_ready0", s0_ready, 0);
      cycles(2);
      rst_off();
      auto_credit = 1'b0;
      push_raw(0, ent(0, 0, 'h77));
      push_raw(0, ent(0, 1, 'h78));
      push_pkt(0, 'h80, 40, 39);
      push_pkt(1, 'h90, 40, 39);
      cycles(120);
      chk("t5_count0", out0.size(), 32);
      chk("t5_first0", out0[0], ent(1, 0, 'h80));
      chk("t5_first1", out1[0], ent(1, 0, 'h90));
      chk("t5_last0", out0[31], ent(0, 0, 'h9F));
      chk("t5_no_mismatch", mis_log.size(), 0);

`ifdef PAIR_STATS_EN
      // Statistics: three clean frames then one mismatch
      rst_on();
      cycles(2);
      rst_off();
      cycles(1);
      chk("st_rst_frames", frame_count, 0);
      chk("st_rst_mis", mismatch_count, 0);
      auto_credit = 1'b1;
      for (int f = 0; f < 3; f++) begin
         push_pkt(0, 'h300 + 4 * f, 2, 1);
         push_pkt(1, 'h400 + 4 * f, 2, 1);
      end
      push_pkt(0, 'h340, 2, 1);
      push_pkt(1, 'h440, 3, 2);
      cycles(40);
      chk("st_frames", frame_count, 3);
      chk("st_mismatches", mismatch_count, 1);
`endif

      chk("lockstep", lock_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
